// File: rtl/prog_load_ctrl.sv
// Program preload / run / state-dump sequencer for the RISC core.
// Loads IM over a valid/ready port, runs the core until HLT or timeout, then streams RF and DM out.
module prog_load_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned IM_AW       = 8,
    parameter int unsigned DM_AW       = 8,
    parameter int unsigned N_DUMP_REGS = 32,
    parameter int unsigned N_DUMP_MEM  = 12,
    parameter int unsigned MAX_CYCLES  = 1000
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [XLEN-1:0]  ld_data,
    input  logic             ld_last,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [XLEN-1:0]  im_wdata,
    output logic             core_rst_n,
    input  logic             halt,
    output logic [4:0]       dbg_rf_addr,
    input  logic [XLEN-1:0]  dbg_rf_rdata,
    output logic [DM_AW-1:0] dbg_dm_addr,
    input  logic [XLEN-1:0]  dbg_dm_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [XLEN-1:0]  dump_data,
    output logic             dump_sel,
    output logic [7:0]       dump_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             overflow,
    output logic [31:0]      cycle_count
);

    localparam int unsigned IDXW = (DM_AW > 8) ? DM_AW : 8;
    localparam logic [IM_AW-1:0] IM_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DUMP_RF, S_DUMP_DM, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IM_AW-1:0] ld_addr_q;
    logic [IDXW-1:0]  idx_q;
    logic [31:0]      cycle_q, cycle_d;
    logic             timeout_q, overflow_q;
    logic             ld_ready_q, core_rst_n_q, dump_valid_q, dump_sel_q, busy_q, done_q;
    logic             ld_hs, dump_hs;

    assign ld_hs   = ld_valid & ld_ready_q;
    assign dump_hs = dump_valid_q & dump_ready;
    assign cycle_d = cycle_q + 32'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:    if (ld_hs && (ld_last || ld_addr_q == IM_LAST)) state_d = S_RUN;
            S_RUN:     if (halt || cycle_d == 32'(MAX_CYCLES)) state_d = S_DUMP_RF;
            S_DUMP_RF: if (dump_hs && idx_q == IDXW'(N_DUMP_REGS - 1)) state_d = S_DUMP_DM;
            S_DUMP_DM: if (dump_hs && idx_q == IDXW'(N_DUMP_MEM - 1)) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ld_addr_q    <= '0;
            idx_q        <= '0;
            cycle_q      <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            ld_ready_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= (state_d == S_LOAD);
            core_rst_n_q <= (state_d == S_RUN);
            dump_valid_q <= (state_d == S_DUMP_RF) || (state_d == S_DUMP_DM);
            dump_sel_q   <= (state_d == S_DUMP_DM);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q       <= (state_d == S_DONE);

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ld_addr_q  <= '0;
                        cycle_q    <= '0;
                        timeout_q  <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_hs) begin
                        // The top address is never wrapped back to 0.
                        if (ld_addr_q != IM_LAST) ld_addr_q <= ld_addr_q + IM_AW'(1);
                        else if (!ld_last)        overflow_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_q <= cycle_d;
                    idx_q   <= '0;
                    if (!halt && cycle_d == 32'(MAX_CYCLES)) timeout_q <= 1'b1;
                end
                S_DUMP_RF: begin
                    if (dump_hs) begin
                        if (idx_q == IDXW'(N_DUMP_REGS - 1)) idx_q <= '0;
                        else                                  idx_q <= idx_q + IDXW'(1);
                    end
                end
                S_DUMP_DM: begin
                    if (dump_hs) idx_q <= idx_q + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign ld_ready    = ld_ready_q;
    assign im_we       = ld_hs;
    assign im_addr     = ld_addr_q;
    assign im_wdata    = ld_data;
    assign core_rst_n  = core_rst_n_q;
    assign dbg_rf_addr = idx_q[4:0];
    assign dbg_dm_addr = idx_q[DM_AW-1:0];
    assign dump_valid  = dump_valid_q;
    assign dump_sel    = dump_sel_q;
    assign dump_idx    = idx_q[7:0];
    assign dump_data   = dump_sel_q ? dbg_dm_rdata : dbg_rf_rdata;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized self-checking bench for prog_load_ctrl: small IM (4 words) and a 16-cycle limit
// so that overflow and timeout are reachable; expectations come from a sequence-level model.
module tb_prog_load_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IM_AW = 2;
    localparam int unsigned DM_AW = 8;
    localparam int unsigned NREG  = 32;
    localparam int unsigned NMEM  = 12;
    localparam int unsigned MAXC  = 16;
    localparam int unsigned DEPTH = 4;

    logic             clk1 = 1'b0;
    logic             rst, start, ld_valid, ld_last, halt, dump_ready;
    logic [XLEN-1:0]  ld_data;
    logic             ld_ready, im_we, core_rst_n, dump_valid, dump_sel, busy, done, timeout, overflow;
    logic [IM_AW-1:0] im_addr;
    logic [XLEN-1:0]  im_wdata, dbg_rf_rdata, dbg_dm_rdata, dump_data;
    logic [4:0]       dbg_rf_addr;
    logic [DM_AW-1:0] dbg_dm_addr;
    logic [7:0]       dump_idx;
    logic [31:0]      cycle_count;

    logic [XLEN-1:0]  rf_mem [32];
    logic [XLEN-1:0]  dm_mem [256];
    logic [31:0]      prog_q [$];

    int errors = 0;
    int checks = 0;
    int exp_cycles, exp_stall;
    bit exp_to, exp_ovf;

    always #5 clk1 = ~clk1;

    assign dbg_rf_rdata = rf_mem[dbg_rf_addr];
    assign dbg_dm_rdata = dm_mem[dbg_dm_addr];

    prog_load_ctrl #(
        .XLEN(XLEN), .IM_AW(IM_AW), .DM_AW(DM_AW),
        .N_DUMP_REGS(NREG), .N_DUMP_MEM(NMEM), .MAX_CYCLES(MAXC)
    ) dut (
        .clk1(clk1), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_rst_n(core_rst_n), .halt(halt),
        .dbg_rf_addr(dbg_rf_addr), .dbg_rf_rdata(dbg_rf_rdata),
        .dbg_dm_addr(dbg_dm_addr), .dbg_dm_rdata(dbg_dm_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_sel(dump_sel), .dump_idx(dump_idx),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
        .cycle_count(cycle_count)
    );

    task automatic fill_mems();
        for (int i = 0; i < 32; i++)  rf_mem[i] = $urandom;
        for (int i = 0; i < 256; i++) dm_mem[i] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        halt = 1'b0; dump_ready = 1'b0;
        fill_mems();
        #2;
        checks++; if ({ld_ready, im_we, dump_valid, busy, done, timeout, overflow, core_rst_n} !== 8'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000000",
                {ld_ready, im_we, dump_valid, busy, done, timeout, overflow, core_rst_n}); end
        checks++; if (cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_cycles: got %0d expected 0", cycle_count); end
        checks++; if ({im_addr, dbg_rf_addr, dbg_dm_addr, dump_idx} !== '0) begin
            errors++; $display("FAIL reset_addr: got %h/%h/%h/%h expected 0", im_addr, dbg_rf_addr, dbg_dm_addr, dump_idx); end
        @(posedge clk1); #1 rst = 1'b1;
        @(negedge clk1);
        checks++; if ({busy, ld_ready, core_rst_n} !== 3'b000) begin
            errors++; $display("FAIL idle_flags: got %b expected 000", {busy, ld_ready, core_rst_n}); end
        @(posedge clk1); #1;
    endtask

    // All scenario tasks begin and end 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        checks++; if ({busy, done, timeout, overflow, ld_ready, core_rst_n} !== 6'b100010) begin
            errors++; $display("FAIL start_flags: got %b expected 100010",
                {busy, done, timeout, overflow, ld_ready, core_rst_n}); end
        checks++; if (cycle_count !== 32'd0 || im_addr !== '0) begin
            errors++; $display("FAIL start_clear: got cyc=%0d addr=%0d expected 0/0", cycle_count, im_addr); end
    endtask

    task automatic load_prog(input int n, input bit with_last);
        int hs = 0;
        exp_ovf = (n > int'(DEPTH)) || (n == int'(DEPTH) && !with_last);
        for (int i = 0; i < n; i++) begin
            if (hs == int'(DEPTH)) begin
                // IM is full: keep offering a word, which must not be taken.
                ld_valid = 1'b1; ld_data = prog_q[i]; ld_last = 1'b0;
                break;
            end
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 1'b0; start = 1'($urandom_range(0, 1));
                @(negedge clk1);
                checks++; if ({ld_ready, im_we, core_rst_n} !== 3'b100) begin
                    errors++; $display("FAIL load_gap: got %b expected 100", {ld_ready, im_we, core_rst_n}); end
                @(posedge clk1); #1;
            end
            start = 1'b0;
            ld_valid = 1'b1; ld_data = prog_q[i]; ld_last = with_last && (i == n - 1);
            @(negedge clk1);
            checks++; if ({ld_ready, im_we, core_rst_n} !== 3'b110) begin
                errors++; $display("FAIL load_hs: got %b expected 110", {ld_ready, im_we, core_rst_n}); end
            checks++; if (im_addr !== IM_AW'(hs) || im_wdata !== prog_q[i]) begin
                errors++; $display("FAIL load_write: got addr=%0d data=%h expected addr=%0d data=%h",
                    im_addr, im_wdata, hs, prog_q[i]); end
            @(posedge clk1); #1;
            hs++;
        end
        if (hs < int'(DEPTH) || n == int'(DEPTH)) ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic run_core(input int halt_at);
        bit in_range = (halt_at >= 1 && halt_at <= int'(MAXC));
        exp_cycles = in_range ? halt_at : int'(MAXC);
        exp_to = !in_range;
        for (int c = 1; c <= exp_cycles; c++) begin
            halt  = (c == halt_at);
            start = 1'($urandom_range(0, 1));
            @(negedge clk1);
            checks++; if ({core_rst_n, ld_ready, im_we, dump_valid, busy} !== 5'b10001) begin
                errors++; $display("FAIL run_flags: cycle %0d got %b expected 10001", c,
                    {core_rst_n, ld_ready, im_we, dump_valid, busy}); end
            checks++; if (cycle_count !== 32'(c - 1)) begin
                errors++; $display("FAIL run_count: got %0d expected %0d", cycle_count, c - 1); end
            @(posedge clk1); #1;
            ld_valid = 1'b0;
        end
        halt = 1'b0; start = 1'b0;
        checks++; if (cycle_count !== 32'(exp_cycles)) begin
            errors++; $display("FAIL run_total: got %0d expected %0d", cycle_count, exp_cycles); end
        checks++; if ({timeout, overflow, core_rst_n} !== {exp_to, exp_ovf, 1'b0}) begin
            errors++; $display("FAIL run_end_flags: got %b expected %b", {timeout, overflow, core_rst_n},
                {exp_to, exp_ovf, 1'b0}); end
    endtask

    task automatic dump_all(input int stall_pos);
        logic        e_sel [$];
        int unsigned e_idx [$];
        logic [31:0] e_dat [$];
        int p = 0, stalls = 0, guard = 0;
        for (int unsigned r = 0; r < NREG; r++) begin e_sel.push_back(1'b0); e_idx.push_back(r); e_dat.push_back(rf_mem[r]); end
        for (int unsigned m = 0; m < NMEM; m++) begin e_sel.push_back(1'b1); e_idx.push_back(m); e_dat.push_back(dm_mem[m]); end
        while (p < e_idx.size() && guard < 1000) begin
            if (p == stall_pos && stalls < 3) begin dump_ready = 1'b0; stalls++; end
            else dump_ready = ($urandom_range(0, 3) != 0);
            start = 1'($urandom_range(0, 1));
            @(negedge clk1);
            checks++; if ({dump_valid, core_rst_n, busy, done} !== 4'b1010) begin
                errors++; $display("FAIL dump_flags: pos %0d got %b expected 1010", p, {dump_valid, core_rst_n, busy, done}); end
            checks++; if (dump_sel !== e_sel[p] || dump_idx !== 8'(e_idx[p]) || dump_data !== e_dat[p]) begin
                errors++; $display("FAIL dump_word: pos %0d got sel=%b idx=%0d data=%h expected sel=%b idx=%0d data=%h",
                    p, dump_sel, dump_idx, dump_data, e_sel[p], e_idx[p], e_dat[p]); end
            checks++; if ((!e_sel[p] && dbg_rf_addr !== 5'(e_idx[p])) || (e_sel[p] && dbg_dm_addr !== DM_AW'(e_idx[p]))) begin
                errors++; $display("FAIL dump_addr: pos %0d got rf=%0d dm=%0d expected %0d", p, dbg_rf_addr, dbg_dm_addr, e_idx[p]); end
            if (dump_ready) p++;
            @(posedge clk1); #1;
            guard++;
        end
        dump_ready = 1'b0; start = 1'b0;
        if (guard >= 1000) begin
            errors++; checks++; $display("FAIL dump_budget: got %0d words expected %0d", p, e_idx.size());
        end
        repeat (2) begin
            @(negedge clk1);
            checks++; if ({done, busy, dump_valid, core_rst_n} !== 4'b1000) begin
                errors++; $display("FAIL done_flags: got %b expected 1000", {done, busy, dump_valid, core_rst_n}); end
            checks++; if (cycle_count !== 32'(exp_cycles) || timeout !== exp_to || overflow !== exp_ovf) begin
                errors++; $display("FAIL done_hold: got cyc=%0d to=%b ovf=%b expected cyc=%0d to=%b ovf=%b",
                    cycle_count, timeout, overflow, exp_cycles, exp_to, exp_ovf); end
            @(posedge clk1); #1;
        end
    endtask

    task automatic run_program(input int n, input bit with_last, input int halt_at, input int stall_pos);
        fill_mems();
        do_start();
        load_prog(n, with_last);
        run_core(halt_at);
        dump_all(stall_pos);
    endtask

    task automatic random_prog(input int n);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back($urandom);
    endtask

    task automatic test_load_halt_stall();
        prog_q.delete();
        prog_q.push_back(32'h00800093);
        prog_q.push_back(32'h00300113);
        prog_q.push_back(32'h01900193);
        run_program(3, 1'b1, 10, 5);
    endtask

    task automatic test_timeout();
        random_prog(2);
        run_program(2, 1'b1, 0, -1);
        random_prog(1);
        run_program(1, 1'b1, int'(MAXC), -1);
    endtask

    task automatic test_overflow();
        random_prog(5);
        run_program(5, 1'b0, 3, -1);
        random_prog(4);
        run_program(4, 1'b1, 2, -1);
    endtask

    task automatic test_reset_mid_load();
        fill_mems();
        do_start();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = $urandom;
            @(posedge clk1); #1;
        end
        ld_valid = 1'b1; ld_data = $urandom;
        #2 rst = 1'b0;
        #1;
        checks++; if ({ld_ready, im_we, busy, core_rst_n, done, overflow} !== 6'b0) begin
            errors++; $display("FAIL midload_reset: got %b expected 000000",
                {ld_ready, im_we, busy, core_rst_n, done, overflow}); end
        checks++; if (im_addr !== '0 || cycle_count !== 32'd0) begin
            errors++; $display("FAIL midload_reset_addr: got addr=%0d cyc=%0d expected 0/0", im_addr, cycle_count); end
        ld_valid = 1'b0;
        @(posedge clk1); #1 rst = 1'b1;
        @(negedge clk1);
        checks++; if ({busy, ld_ready} !== 2'b00) begin
            errors++; $display("FAIL midload_idle: got %b expected 00", {busy, ld_ready}); end
        @(posedge clk1); #1;
        random_prog(3);
        run_program(3, 1'b1, 7, -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 6);
            bit wl = (n < int'(DEPTH)) ? 1'b1 : 1'($urandom_range(0, 1));
            random_prog(n);
            run_program(n, wl, $urandom_range(0, 20), $urandom_range(0, 43));
        end
    endtask

    initial begin
        test_reset();
        test_load_halt_stall();
        test_timeout();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
